branch_hazard_ctrl: RTL and testbench

// - Pipeline sequencer around the branch resolver. Takes the resolved PCSource (taken) from EX,
//   the branch-in-ID decode and the flag-writer-in-EX indication, and drives PC write,
//   IF/ID write enable and the IF/ID and ID/EX flush signals.
// - Handles three hazards: taken-branch flush, flag hazard for a branch in ID, external

---
 rtl/branch_hazard_ctrl_if.sv | 31 +++
 rtl/branch_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_branch_hazard_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/branch_hazard_ctrl_if.sv
// Branch/hazard sequencer bundle: pipeline status in, pipeline register controls out.
// Latency: none, wires only.
// Backpressure: carried as pc_write / if_id_write enables toward the pipeline.
interface branch_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             ex_br_valid;
  logic             ex_pc_source;
  logic             id_is_branch;
  logic             ex_sets_flags;
  logic             ext_stall;
  logic             pc_write;
  logic             if_id_write;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             busy;
  logic [CNT_W-1:0] taken_cnt;
  logic [CNT_W-1:0] stall_cnt;

  // Pipeline side: reports branch/flag/stall status, consumes the controls.
  modport master (
    output ex_br_valid, ex_pc_source, id_is_branch, ex_sets_flags, ext_stall,
    input  pc_write, if_id_write, flush_if_id, flush_id_ex, busy, taken_cnt, stall_cnt
  );

  // Controller side.
  modport slave (
    input  ex_br_valid, ex_pc_source, id_is_branch, ex_sets_flags, ext_stall,
    output pc_write, if_id_write, flush_if_id, flush_id_ex, busy, taken_cnt, stall_cnt
  );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// Branch hazard sequencer: redirect flush, flag-hazard stall, load-use stall.
// Latency: Mealy controls in the same cycle; FLUSH_EXTRA extra flush cycles after redirect.
// Backpressure: deasserts pc_write/if_id_write on stalls. Macro BRANCH_STATS_EN adds counters.
module branch_hazard_ctrl #(
  parameter int FLUSH_EXTRA = 0,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    FLAG_WAIT = 2'd1,
    FLUSH     = 2'd2
  } state_t;

  localparam bit       HAS_FLUSH  = (FLUSH_EXTRA > 0);
  localparam logic [2:0] FLUSH_INIT = HAS_FLUSH ? 3'(FLUSH_EXTRA - 1) : 3'd0;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic redirect;
  logic flag_haz;
  logic stall_hit;

  logic pc_write, if_id_write, flush_if_id, flush_id_ex, busy;

  // Hazard classification; FLUSH ignores all requests, flag hazard only checked in RUN.
  always_comb begin
    redirect  = bus.ex_br_valid & bus.ex_pc_source & (state_q != FLUSH);
    flag_haz  = (state_q == RUN) & bus.id_is_branch & bus.ex_sets_flags & ~redirect;
    stall_hit = (state_q != FLUSH) & bus.ext_stall & ~redirect & ~flag_haz;
  end

  // State register with synchronous reset; abandons any FLUSH/FLAG_WAIT in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: redirect enters FLUSH (if configured), flag hazard waits one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN, FLAG_WAIT: begin
        if (redirect) begin
          if (HAS_FLUSH) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_INIT;
          end else begin
            state_d = RUN;
          end
        end else if (flag_haz) begin
          state_d = FLAG_WAIT;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (cnt_q == 3'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Mealy outputs; reset holds the pipeline frozen with both stages bubbled.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    busy        = (state_q != RUN);
    if (!rst_n) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      busy        = 1'b0;
    end else if (state_q == FLUSH || redirect) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (flag_haz || stall_hit) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      flush_id_ex = 1'b1;
    end
  end

  assign bus.pc_write    = pc_write;
  assign bus.if_id_write = if_id_write;
  assign bus.flush_if_id = flush_if_id;
  assign bus.flush_id_ex = flush_id_ex;
  assign bus.busy        = busy;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] taken_q, stall_q;

  // Saturating statistics: taken redirects and stall cycles (flag or external).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      taken_q <= '0;
      stall_q <= '0;
    end else begin
      if (redirect && (taken_q != {CNT_W{1'b1}}))
        taken_q <= taken_q + 1'b1;
      if ((flag_haz || stall_hit) && (stall_q != {CNT_W{1'b1}}))
        stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.taken_cnt = taken_q;
  assign bus.stall_cnt = stall_q;
`else
  assign bus.taken_cnt = '0;
  assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Bench for branch_hazard_ctrl: two instances (no extra flush / two extra flush cycles).
// Vectors carry inputs and expected Mealy outputs; expectations go through a queue.
// Counter expectations are tracked per instance from per-vector count flags.
module tb_branch_hazard_ctrl;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_hazard_ctrl_if #(.CNT_W(CW)) bus0 ();
  branch_hazard_ctrl_if #(.CNT_W(CW)) bus2 ();

  branch_hazard_ctrl #(.FLUSH_EXTRA(0), .CNT_W(CW)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  branch_hazard_ctrl #(.FLUSH_EXTRA(2), .CNT_W(CW)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  // in  = {rst_n, ex_br_valid, ex_pc_source, id_is_branch, ex_sets_flags, ext_stall}
  // out = {pc_write, if_id_write, flush_if_id, flush_id_ex, busy}
  typedef struct {
    bit       sel;
    logic [5:0] in;
    logic [4:0] out;
    bit       tk;
    bit       st;
  } vec_t;

  typedef struct {
    bit          sel;
    logic [4:0]  out;
    logic [CW-1:0] tk;
    logic [CW-1:0] st;
    int          idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  logic [CW-1:0] exp_tk [2];
  logic [CW-1:0] exp_st [2];
  int total = 0;
  int bad = 0;

  function automatic vec_t mk(bit sel, logic [5:0] in, logic [4:0] out, bit tk, bit st);
    vec_t v;
    v.sel = sel; v.in = in; v.out = out; v.tk = tk; v.st = st;
    return v;
  endfunction

  task automatic check(string nm, int idx, logic [7:0] act, logic [7:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s vec=%0d actual=%b expected=%b", nm, idx, act, expv);
    end
  endtask

  task automatic drive_inputs(bit sel, logic [5:0] in);
    bus0.ex_br_valid   = sel ? 1'b0 : in[4];
    bus0.ex_pc_source  = sel ? 1'b0 : in[3];
    bus0.id_is_branch  = sel ? 1'b0 : in[2];
    bus0.ex_sets_flags = sel ? 1'b0 : in[1];
    bus0.ext_stall     = sel ? 1'b0 : in[0];
    bus2.ex_br_valid   = sel ? in[4] : 1'b0;
    bus2.ex_pc_source  = sel ? in[3] : 1'b0;
    bus2.id_is_branch  = sel ? in[2] : 1'b0;
    bus2.ex_sets_flags = sel ? in[1] : 1'b0;
    bus2.ext_stall     = sel ? in[0] : 1'b0;
  endtask

  task automatic run_vec(vec_t v, int idx);
    exp_t e;
    exp_t g;
    logic [4:0] act;
    logic [CW-1:0] atk, ast;
    int s;
    s = v.sel ? 1 : 0;
    @(posedge clk);
    #1;
    rst_n = v.in[5];
    drive_inputs(v.sel, v.in);
    e.sel = v.sel;
    e.out = v.out;
    e.idx = idx;
`ifdef BRANCH_STATS_EN
    e.tk = exp_tk[s];
    e.st = exp_st[s];
`else
    e.tk = '0;
    e.st = '0;
`endif
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    if (g.sel) begin
      act = {bus2.pc_write, bus2.if_id_write, bus2.flush_if_id, bus2.flush_id_ex, bus2.busy};
      atk = bus2.taken_cnt;
      ast = bus2.stall_cnt;
    end else begin
      act = {bus0.pc_write, bus0.if_id_write, bus0.flush_if_id, bus0.flush_id_ex, bus0.busy};
      atk = bus0.taken_cnt;
      ast = bus0.stall_cnt;
    end
    check(g.sel ? "outs_fx2" : "outs_fx0", g.idx, {3'b0, act}, {3'b0, g.out});
    check("taken_cnt", g.idx, {4'b0, atk}, {4'b0, g.tk});
    check("stall_cnt", g.idx, {4'b0, ast}, {4'b0, g.st});
    if (!v.in[5]) begin
      exp_tk[0] = '0; exp_tk[1] = '0;
      exp_st[0] = '0; exp_st[1] = '0;
    end else begin
      if (v.tk && exp_tk[s] != {CW{1'b1}}) exp_tk[s] = exp_tk[s] + 1'b1;
      if (v.st && exp_st[s] != {CW{1'b1}}) exp_st[s] = exp_st[s] + 1'b1;
    end
  endtask

  initial begin
    logic [CW-1:0] sat_exp;
    drive_inputs(1'b0, 6'b0);
    exp_tk[0] = '0; exp_tk[1] = '0;
    exp_st[0] = '0; exp_st[1] = '0;

    // No extra flush: reset, taken, non-taken, flag hazard, stalls, priority, reset mid-wait.
    vecs.push_back(mk(0, 6'b0_00000, 5'b00110, 0, 0));
    vecs.push_back(mk(0, 6'b0_00000, 5'b00110, 0, 0));
    vecs.push_back(mk(0, 6'b0_00000, 5'b00110, 0, 0));
    vecs.push_back(mk(0, 6'b1_00000, 5'b11000, 0, 0));
    vecs.push_back(mk(0, 6'b1_11000, 5'b11110, 1, 0));
    vecs.push_back(mk(0, 6'b1_00000, 5'b11000, 0, 0));
    vecs.push_back(mk(0, 6'b1_10000, 5'b11000, 0, 0));
    vecs.push_back(mk(0, 6'b1_01000, 5'b11000, 0, 0));
    vecs.push_back(mk(0, 6'b1_00110, 5'b00010, 0, 1));
    vecs.push_back(mk(0, 6'b1_00110, 5'b11001, 0, 0));
    vecs.push_back(mk(0, 6'b1_00000, 5'b11000, 0, 0));
    vecs.push_back(mk(0, 6'b1_00001, 5'b00010, 0, 1));
    vecs.push_back(mk(0, 6'b1_11111, 5'b11110, 1, 0));
    vecs.push_back(mk(0, 6'b1_00110, 5'b00010, 0, 1));
    vecs.push_back(mk(0, 6'b1_00111, 5'b00011, 0, 1));
    vecs.push_back(mk(0, 6'b1_00110, 5'b00010, 0, 1));
    vecs.push_back(mk(0, 6'b1_11000, 5'b11111, 1, 0));
    vecs.push_back(mk(0, 6'b1_00000, 5'b11000, 0, 0));
    vecs.push_back(mk(0, 6'b1_00110, 5'b00010, 0, 1));
    vecs.push_back(mk(0, 6'b0_00110, 5'b00110, 0, 0));
    vecs.push_back(mk(0, 6'b1_00000, 5'b11000, 0, 0));
    // Two extra flush cycles: ignored second pulse and stall, reset mid-flush, FLAG_WAIT redirect.
    vecs.push_back(mk(1, 6'b0_00000, 5'b00110, 0, 0));
    vecs.push_back(mk(1, 6'b1_11000, 5'b11110, 1, 0));
    vecs.push_back(mk(1, 6'b1_11000, 5'b11111, 0, 0));
    vecs.push_back(mk(1, 6'b1_00001, 5'b11111, 0, 0));
    vecs.push_back(mk(1, 6'b1_00000, 5'b11000, 0, 0));
    vecs.push_back(mk(1, 6'b1_11000, 5'b11110, 1, 0));
    vecs.push_back(mk(1, 6'b0_00000, 5'b00110, 0, 0));
    vecs.push_back(mk(1, 6'b1_00000, 5'b11000, 0, 0));
    vecs.push_back(mk(1, 6'b1_00110, 5'b00010, 0, 1));
    vecs.push_back(mk(1, 6'b1_11000, 5'b11111, 1, 0));
    vecs.push_back(mk(1, 6'b1_00000, 5'b11111, 0, 0));
    vecs.push_back(mk(1, 6'b1_00000, 5'b11111, 0, 0));
    vecs.push_back(mk(1, 6'b1_00000, 5'b11000, 0, 0));

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Saturation: 20 back-to-back taken branches after a fresh reset.
    run_vec(mk(0, 6'b0_00000, 5'b00110, 0, 0), 100);
    for (int i = 0; i < 20; i++) run_vec(mk(0, 6'b1_11000, 5'b11110, 1, 0), 101 + i);
    run_vec(mk(0, 6'b1_00000, 5'b11000, 0, 0), 121);
`ifdef BRANCH_STATS_EN
    sat_exp = 4'd15;
`else
    sat_exp = 4'd0;
`endif
    check("taken_sat", 122, {4'b0, bus0.taken_cnt}, {4'b0, sat_exp});

    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left actual=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
